obi_buffer: RTL and testbench

Single-clock OBI request/response buffer placed between an OBI controller and a secondary bus segment. It decouples the controller's request handshake through a parametrised request FIFO, throttles the number of outstanding secondary transactions, and optionally registers the response path. It is the same-clock counterpart of the team's OBI CDC bridges, generalised in width, depth and outstanding-transaction limit, and used where timing closure, not clock crossing, is the concern.

---
 rtl/obi_pkg.sv | 27 ++
 rtl/obi_sync_fifo.sv | 47 ++++
 rtl/obi_buffer.sv | 121 ++++++++++++
 tb/tb_obi_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI request-word layout helpers.
// Word layout (MSB..LSB): {addr, we, be, wdata}.
package obi_pkg;

   function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
      return aw + 1 + dw / 8 + dw;
   endfunction

   function automatic int unsigned wdata_lsb();
      return 0;
   endfunction

   function automatic int unsigned be_lsb(input int unsigned dw);
      return dw;
   endfunction

   function automatic int unsigned we_bit(input int unsigned dw);
      return dw + dw / 8;
   endfunction

   function automatic int unsigned addr_lsb(input int unsigned dw);
      return dw + dw / 8 + 1;
   endfunction

   localparam int unsigned OBI_REQ_W_DEFAULT = 32 + 1 + 4 + 32;

endpackage

// File: rtl/obi_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// The head comes straight from storage, so a push is never visible on the same cycle.
module obi_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q[PTR_W-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_q[PTR_W-1:0]] <= data_i;
            wr_q                   <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/obi_buffer.sv
// Same-clock OBI request/response buffer: request FIFO, outstanding-transaction throttle,
// optional response register and a sticky protocol error flag.
module obi_buffer
   import obi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned REQ_DEPTH       = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned RESP_REG        = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ctrl_req_i,
   output logic                    ctrl_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   ctrl_addr_i,
   input  logic                    ctrl_we_i,
   input  logic [DATA_WIDTH/8-1:0] ctrl_be_i,
   input  logic [DATA_WIDTH-1:0]   ctrl_wdata_i,
   output logic                    ctrl_rvalid_o,
   output logic [DATA_WIDTH-1:0]   ctrl_rdata_o,
   output logic                    secondary_req_o,
   input  logic                    secondary_gnt_i,
   output logic [ADDR_WIDTH-1:0]   secondary_addr_o,
   output logic                    secondary_we_o,
   output logic [DATA_WIDTH/8-1:0] secondary_be_o,
   output logic [DATA_WIDTH-1:0]   secondary_wdata_o,
   input  logic                    secondary_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   secondary_rdata_i,
   output logic                    protocol_err_o
);

   localparam int unsigned REQ_W    = req_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int unsigned BE_W     = DATA_WIDTH / 8;
   localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned BE_LSB   = be_lsb(DATA_WIDTH);
   localparam int unsigned WE_BIT   = we_bit(DATA_WIDTH);
   localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam int unsigned WD_LSB   = wdata_lsb();

   logic [REQ_W-1:0] push_data, head;
   logic             full, empty, push, pop;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic             err_q, err_d;

   assign push_data = {ctrl_addr_i, ctrl_we_i, ctrl_be_i, ctrl_wdata_i};

   // Grant is held low during reset even though the FIFO already reads as empty.
   assign ctrl_gnt_o      = rst_ni && !full;
   assign push            = ctrl_req_i && ctrl_gnt_o;
   assign secondary_req_o = !empty && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
   assign pop             = secondary_req_o && secondary_gnt_i;

   obi_sync_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (REQ_DEPTH)
   ) u_req_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign secondary_addr_o  = head[ADDR_LSB +: ADDR_WIDTH];
   assign secondary_we_o    = head[WE_BIT];
   assign secondary_be_o    = head[BE_LSB +: BE_W];
   assign secondary_wdata_o = head[WD_LSB +: DATA_WIDTH];

   always_comb begin
      outstanding_d = outstanding_q;
      err_d         = err_q;
      if (secondary_rvalid_i && (outstanding_q == '0)) begin
         err_d = 1'b1;
      end
      if (pop && !secondary_rvalid_i) begin
         outstanding_d = outstanding_q + CNT_W'(1);
      end else if (secondary_rvalid_i && !pop && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   assign protocol_err_o = err_q;

   if (RESP_REG != 0) begin : g_resp_reg
      logic                  rvalid_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
         end else begin
            rvalid_q <= secondary_rvalid_i;
            if (secondary_rvalid_i) begin
               rdata_q <= secondary_rdata_i;
            end
         end
      end

      assign ctrl_rvalid_o = rvalid_q;
      assign ctrl_rdata_o  = rdata_q;
   end else begin : g_resp_wire
      assign ctrl_rvalid_o = secondary_rvalid_i;
      assign ctrl_rdata_o  = secondary_rdata_i;
   end

endmodule

// File: tb/tb_obi_buffer.sv
// Scoreboard bench for obi_buffer: random traffic against a queue-based model of the
// buffer's occupancy and outstanding count; a monitor checks every DUT handshake in order.
module tb_obi_buffer;

   localparam int DEPTH = 2;
   localparam int MAXO  = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        ctrl_req, ctrl_gnt, ctrl_we, ctrl_rvalid;
   logic [31:0] ctrl_addr, ctrl_wdata, ctrl_rdata;
   logic [3:0]  ctrl_be;
   logic        sec_req, sec_gnt, sec_we, sec_rvalid, protocol_err;
   logic [31:0] sec_addr, sec_wdata, sec_rdata;
   logic [3:0]  sec_be;

   always #5 clk = ~clk;

   obi_buffer #(
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .REQ_DEPTH       (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .RESP_REG        (1)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .ctrl_req_i         (ctrl_req),
      .ctrl_gnt_o         (ctrl_gnt),
      .ctrl_addr_i        (ctrl_addr),
      .ctrl_we_i          (ctrl_we),
      .ctrl_be_i          (ctrl_be),
      .ctrl_wdata_i       (ctrl_wdata),
      .ctrl_rvalid_o      (ctrl_rvalid),
      .ctrl_rdata_o       (ctrl_rdata),
      .secondary_req_o    (sec_req),
      .secondary_gnt_i    (sec_gnt),
      .secondary_addr_o   (sec_addr),
      .secondary_we_o     (sec_we),
      .secondary_be_o     (sec_be),
      .secondary_wdata_o  (sec_wdata),
      .secondary_rvalid_i (sec_rvalid),
      .secondary_rdata_i  (sec_rdata),
      .protocol_err_o     (protocol_err)
   );

   req_t  exp_req_q[$];
   resp_t exp_resp_q[$];
   req_t  mon_e;
   resp_t mon_r;
   int    n_checks = 0;
   int    n_err = 0;
   int    cyc = 0;
   bit    mon_en = 1'b0;
   int    m_cnt = 0;
   int    m_out = 0;
   bit    m_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic req_t rnd_req();
      req_t r;
      r.addr  = $urandom;
      r.we    = 1'($urandom_range(0, 1));
      r.be    = 4'($urandom_range(0, 15));
      r.wdata = $urandom;
      return r;
   endfunction

   // Monitor: sampled late in each cycle, away from both edges.
   always begin
      @(negedge clk);
      #3;
      if (mon_en && rst_ni) begin
         if (sec_req && sec_gnt) begin
            if (exp_req_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL sec_handshake: got unexpected request, required none (cycle %0d)",
                        cyc);
            end else begin
               mon_e = exp_req_q.pop_front();
               chk("sec_fields", {sec_addr, sec_we, sec_be, sec_wdata}, mon_e);
            end
         end
         if (ctrl_rvalid) begin
            if (exp_resp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL ctrl_rvalid: got unexpected response, required none (cycle %0d)",
                        cyc);
            end else begin
               mon_r = exp_resp_q.pop_front();
               chk("ctrl_rdata", ctrl_rdata, mon_r.data);
               chk("resp_latency", cyc, mon_r.due);
            end
         end else if (exp_resp_q.size() != 0 && exp_resp_q[0].due <= cyc) begin
            mon_r = exp_resp_q.pop_front();
            n_checks++;
            n_err++;
            $display("FAIL resp_missing: got no rvalid, required rdata %0h (cycle %0d)",
                     mon_r.data, cyc);
         end
      end
   end

   // One bus cycle: check outputs against the model, drive inputs, then advance the model.
   task automatic step(input logic req, input logic sgnt, input logic rv, input req_t r,
                       input logic [31:0] rd);
      bit push, pop;
      @(negedge clk);
      #1;
      chk("ctrl_gnt", ctrl_gnt, m_cnt < DEPTH);
      chk("sec_req", sec_req, (m_cnt > 0) && (m_out < MAXO));
      chk("protocol_err", protocol_err, m_err);
      ctrl_req   = req;
      ctrl_addr  = r.addr;
      ctrl_we    = r.we;
      ctrl_be    = r.be;
      ctrl_wdata = r.wdata;
      sec_gnt    = sgnt;
      sec_rvalid = rv;
      sec_rdata  = rd;
      push = req && (m_cnt < DEPTH);
      pop  = sgnt && (m_cnt > 0) && (m_out < MAXO);
      if (push) exp_req_q.push_back(r);
      if (rv) exp_resp_q.push_back('{rd, cyc + 1});
      @(posedge clk);
      if (rv && m_out == 0) m_err = 1'b1;
      if (push) m_cnt++;
      if (pop) m_cnt--;
      if (pop && !rv) m_out++;
      else if (rv && !pop && m_out > 0) m_out--;
   endtask

   task automatic idle_inputs();
      ctrl_req   = 1'b0;
      ctrl_addr  = '0;
      ctrl_we    = 1'b0;
      ctrl_be    = '0;
      ctrl_wdata = '0;
      sec_gnt    = 1'b0;
      sec_rvalid = 1'b0;
      sec_rdata  = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_gnt"}, ctrl_gnt, 1'b0);
      chk({tag, "_sec_req"}, sec_req, 1'b0);
      chk({tag, "_rvalid"}, ctrl_rvalid, 1'b0);
      chk({tag, "_rdata"}, ctrl_rdata, 32'h0);
      chk({tag, "_err"}, protocol_err, 1'b0);
   endtask

   req_t r;

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      mon_en = 1'b1;

      // Single write, popped on the following cycle, then a read response.
      r = '{addr: 32'h1000, we: 1'b1, be: 4'hF, wdata: 32'hDEADBEEF};
      step(1'b1, 1'b0, 1'b0, r, '0);
      step(1'b0, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b1, rnd_req(), 32'hCAFEF00D);

      // Back-pressure: third request waits for the first secondary grant.
      step(1'b1, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b1, 1'b0, 1'b0, rnd_req(), '0);
      r = rnd_req();
      step(1'b1, 1'b0, 1'b0, r, '0);
      step(1'b1, 1'b1, 1'b0, r, '0);
      step(1'b1, 1'b0, 1'b0, r, '0);

      // Throttle at MAXO outstanding, released by a single response.
      step(1'b0, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b1, 1'b1, rnd_req(), $urandom);
      step(1'b0, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b1, rnd_req(), $urandom);
      step(1'b0, 1'b0, 1'b1, rnd_req(), $urandom);

      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
              (m_out > 0) && ($urandom_range(0, 9) < 4), rnd_req(), $urandom);
      end

      for (int i = 0; i < 40 && (m_cnt > 0 || m_out > 0); i++) begin
         step(1'b0, 1'b1, m_out > 0, rnd_req(), $urandom);
      end
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);
      chk("req_queue_drained", exp_req_q.size(), 0);
      chk("resp_queue_drained", exp_resp_q.size(), 0);

      // Unsolicited response: forwarded, and the error flag sticks.
      step(1'b0, 1'b0, 1'b1, rnd_req(), 32'h12345678);
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);

      // Reset with two buffered and two outstanding transactions.
      step(1'b1, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b1, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b1, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b1, 1'b0, 1'b0, rnd_req(), '0);
      @(negedge clk);
      #1;
      chk("pre_reset_full", ctrl_gnt, 1'b0);
      chk("pre_reset_err", protocol_err, 1'b1);
      mon_en = 1'b0;
      rst_ni = 1'b0;
      idle_inputs();
      #1;
      check_reset_outputs("midrst");
      exp_req_q.delete();
      exp_resp_q.delete();
      m_cnt = 0;
      m_out = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      mon_en = 1'b1;

      step(1'b1, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b1, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b1, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b1, rnd_req(), $urandom);
      step(1'b0, 1'b0, 1'b1, rnd_req(), $urandom);
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);
      step(1'b0, 1'b0, 1'b0, rnd_req(), '0);
      chk("post_reset_req_queue", exp_req_q.size(), 0);
      chk("post_reset_resp_queue", exp_resp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
